// File: rtl/vc_link_scheduler_if.sv
//------------------------------------------------------------------------------
// vc_link_scheduler_if
// Link-side bundle of the VC link scheduler: VC buffer heads, link output, credits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vc_link_scheduler_if #(
  parameter int N_VC   = 3,
  parameter int FLIT_W = 34
);
  logic [N_VC*FLIT_W-1:0] fdata_i;
  logic [N_VC-1:0]        valid_i;
  logic [N_VC-1:0]        ready_o;
  logic [FLIT_W-1:0]      fdata_o;
  logic [1:0]             vc_id_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [N_VC-1:0]        credit_i;
  logic                   error_o;

  // Scheduler side
  modport master (
    input  fdata_i, valid_i, ready_i, credit_i,
    output ready_o, fdata_o, vc_id_o, valid_o, error_o
  );

  // Environment side: VC buffers, link sink and credit return
  modport slave (
    output fdata_i, valid_i, ready_i, credit_i,
    input  ready_o, fdata_o, vc_id_o, valid_o, error_o
  );
endinterface

`default_nettype wire

// File: rtl/vc_link_scheduler.sv
//------------------------------------------------------------------------------
// vc_link_scheduler
// Round-robin credit-based VC scheduler for one output link with framing checks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vc_link_scheduler #(
  parameter int N_VC      = 3,
  parameter int BUF_DEPTH = 2,
  parameter int FLIT_W    = 34
) (
  input  wire                  clk,
  input  wire                  arst,
  vc_link_scheduler_if.master  lnk
);

  localparam int               CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_DEPTH);
  localparam logic [1:0]       LAST_VC  = 2'(N_VC - 1);
  localparam logic [1:0]       T_HEAD   = 2'b00;
  localparam logic [1:0]       T_SINGLE = 2'b10;
  localparam logic [1:0]       T_TAIL   = 2'b11;

  logic [FLIT_W-1:0] flit [4];
  logic [3:0]        eligible;
  logic [3:0]        cred_err;
  logic [3:0]        frame_err;
  logic [1:0]        grant;
  logic [1:0]        rr_ptr;
  logic [2:0]        idx;
  logic              any_elig;
  logic              load;

  logic [FLIT_W-1:0] out_flit;
  logic [1:0]        out_vc;
  logic              out_valid;
  logic              err;

  // Array padded to four entries so a 2-bit grant always indexes in range.
  for (genvar v = 0; v < 4; v++) begin : g_vc
    if (v < N_VC) begin : g_live
      logic [CNT_W-1:0] credit;
      logic             in_pkt;
      logic             pop;
      logic             ret;
      logic [1:0]       ftype;

      assign flit[v]        = lnk.fdata_i[v*FLIT_W +: FLIT_W];
      assign ftype          = flit[v][FLIT_W-1:FLIT_W-2];
      assign pop            = load && (grant == 2'(v));
      assign ret            = lnk.credit_i[v];
      assign eligible[v]    = lnk.valid_i[v] && (credit != '0);
      assign lnk.ready_o[v] = pop;
      assign cred_err[v]    = ret && !pop && (credit == CNT_MAX);
      assign frame_err[v]   = pop && (((ftype == T_HEAD) || (ftype == T_SINGLE)) ? in_pkt : !in_pkt);

      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          credit <= CNT_MAX;
        end else if (ret && !pop) begin
          if (credit != CNT_MAX) begin
            credit <= credit + CNT_W'(1);
          end
        end else if (pop && !ret) begin
          credit <= credit - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          in_pkt <= 1'b0;
        end else if (pop) begin
          if (ftype == T_HEAD) begin
            in_pkt <= 1'b1;
          end else if (ftype == T_TAIL) begin
            in_pkt <= 1'b0;
          end
        end
      end
    end else begin : g_absent
      assign flit[v]      = '0;
      assign eligible[v]  = 1'b0;
      assign cred_err[v]  = 1'b0;
      assign frame_err[v] = 1'b0;
    end
  end

  // First eligible VC at or after rr_ptr, wrapping modulo N_VC.
  always_comb begin
    grant    = rr_ptr;
    any_elig = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_VC; k++) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= 3'(N_VC)) begin
        idx = idx - 3'(N_VC);
      end
      if (!any_elig && eligible[idx[1:0]]) begin
        any_elig = 1'b1;
        grant    = idx[1:0];
      end
    end
  end

  assign load = (!out_valid || lnk.ready_i) && any_elig;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      out_flit  <= '0;
      out_vc    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        out_flit  <= flit[grant];
        out_vc    <= grant;
        out_valid <= 1'b1;
        rr_ptr    <= (grant == LAST_VC) ? 2'd0 : grant + 2'd1;
      end else if (out_valid && lnk.ready_i) begin
        out_valid <= 1'b0;
      end
      if ((|cred_err) || (|frame_err)) begin
        err <= 1'b1;
      end
    end
  end

  assign lnk.fdata_o = out_flit;
  assign lnk.vc_id_o = out_vc;
  assign lnk.valid_o = out_valid;
  assign lnk.error_o = err;

endmodule

`default_nettype wire

// File: tb/tb_vc_link_scheduler.sv
//------------------------------------------------------------------------------
// tb_vc_link_scheduler
// Directed and randomized checks of vc_link_scheduler against a behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vc_link_scheduler;

  localparam int N  = 3;
  localparam int BD = 2;
  localparam int FW = 34;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  vc_link_scheduler_if #(.N_VC(N), .FLIT_W(FW)) lnk ();

  vc_link_scheduler #(.N_VC(N), .BUF_DEPTH(BD), .FLIT_W(FW)) dut (
    .clk  (clk),
    .arst (arst),
    .lnk  (lnk.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_valid;
  logic [FW-1:0] m_fdata;
  int            m_vc;
  bit            m_err;
  int            m_cred  [N];
  bit            m_inpkt [N];
  int            m_rr;

  // Flit sources and downstream bookkeeping
  logic [FW-1:0] src_flit [N];
  bit            src_in   [N];
  int            src_seq  [N];
  int            pops     [N];
  int            pend     [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_flit(input int v, input logic [FW-1:0] f);
    src_flit[v] = f;
    lnk.fdata_i[v*FW +: FW] = f;
  endtask

  // Legal per-VC packet stream: head (body)* tail, or single head+tail flits.
  task automatic gen(input int v);
    logic [1:0] t;
    if (!src_in[v]) begin
      t = ($urandom_range(2) == 0) ? 2'b10 : 2'b00;
      if (t == 2'b00) src_in[v] = 1'b1;
    end else begin
      t = ($urandom_range(1) == 1) ? 2'b01 : 2'b11;
      if (t == 2'b11) src_in[v] = 1'b0;
    end
    set_flit(v, {t, 8'(v), 24'(src_seq[v])});
    src_seq[v]++;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_fdata = '0;
    m_vc    = 0;
    m_err   = 1'b0;
    m_rr    = 0;
    for (int v = 0; v < N; v++) begin
      m_cred[v]  = BD;
      m_inpkt[v] = 1'b0;
      src_in[v]  = 1'b0;
      pops[v]    = 0;
      pend[v]    = 0;
      gen(v);
    end
  endtask

  task automatic do_reset();
    lnk.valid_i  = '0;
    lnk.credit_i = '0;
    arst = 1'b0;
    #2;
    model_reset();
    chk("rst_valid", lnk.valid_o, 0);
    chk("rst_fdata", lnk.fdata_o, 0);
    chk("rst_vc_id", lnk.vc_id_o, 0);
    chk("rst_error", lnk.error_o, 0);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare DUT to model at the falling edge, then advance the model.
  task automatic tick();
    int         g;
    int         v;
    bit         any;
    bit         ld;
    bit         dec;
    bit         inc;
    logic [1:0] t;
    logic [N-1:0] er;
    @(negedge clk);
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < N; k++) begin
      v = (m_rr + k) % N;
      if (!any && lnk.valid_i[v] && m_cred[v] > 0) begin
        any = 1'b1;
        g   = v;
      end
    end
    ld = any && (!m_valid || lnk.ready_i);
    er = ld ? (N'(1) << g) : '0;
    chk("ready_o", lnk.ready_o, er);
    chk("valid_o", lnk.valid_o, m_valid);
    chk("fdata_o", lnk.fdata_o, m_fdata);
    chk("vc_id_o", lnk.vc_id_o, m_vc);
    chk("error_o", lnk.error_o, m_err);
    @(posedge clk);
    #1;
    for (int w = 0; w < N; w++) begin
      dec = ld && (g == w);
      inc = lnk.credit_i[w];
      if (inc && !dec) begin
        if (m_cred[w] == BD) m_err = 1'b1;
        else m_cred[w]++;
      end else if (dec && !inc) begin
        m_cred[w]--;
      end
    end
    if (m_valid && lnk.ready_i) pend[m_vc]++;
    if (ld) begin
      t = src_flit[g][FW-1 -: 2];
      case (t)
        2'b00: begin if (m_inpkt[g]) m_err = 1'b1; m_inpkt[g] = 1'b1; end
        2'b01: begin if (!m_inpkt[g]) m_err = 1'b1; end
        2'b11: begin if (!m_inpkt[g]) m_err = 1'b1; m_inpkt[g] = 1'b0; end
        default: begin if (m_inpkt[g]) m_err = 1'b1; end
      endcase
      m_fdata = src_flit[g];
      m_vc    = g;
      m_valid = 1'b1;
      m_rr    = (g + 1) % N;
      pops[g]++;
    end else if (m_valid && lnk.ready_i) begin
      m_valid = 1'b0;
    end
    lnk.credit_i = '0;
    if (ld) gen(g);
  endtask

  initial begin
    int            exp_seq [6];
    logic [FW-1:0] held;
    logic [FW-1:0] nxt;
    int            total;

    arst         = 1'b0;
    lnk.fdata_i  = '0;
    lnk.valid_i  = '0;
    lnk.ready_i  = 1'b0;
    lnk.credit_i = '0;

    // Round-robin over all VCs until credits run out
    do_reset();
    exp_seq = '{0, 1, 2, 0, 1, 2};
    lnk.valid_i = 3'b111;
    lnk.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_vc_seq", lnk.vc_id_o, exp_seq[i]);
      chk("t1_valid", lnk.valid_o, 1);
    end
    chk("t1_exhausted", lnk.ready_o, 0);
    tick();
    chk("t1_drained", lnk.valid_o, 0);

    // Single VC limited to BUF_DEPTH flits, then one credit gives one more
    do_reset();
    lnk.valid_i = 3'b010;
    lnk.ready_i = 1'b1;
    repeat (4) tick();
    chk("t2_pops", pops[1], 2);
    chk("t2_blocked", lnk.ready_o, 0);
    lnk.credit_i = 3'b010;
    tick();
    chk("t2_after_credit", lnk.ready_o, 3'b010);
    tick();
    chk("t2_vc", lnk.vc_id_o, 1);
    chk("t2_pops3", pops[1], 3);

    // Back-pressure hold, then reload in the release cycle
    do_reset();
    lnk.valid_i = 3'b001;
    lnk.ready_i = 1'b0;
    tick();
    held = lnk.fdata_o;
    repeat (5) begin
      tick();
      chk("t3_hold", lnk.fdata_o, held);
      chk("t3_no_pop", lnk.ready_o, 0);
    end
    lnk.ready_i = 1'b1;
    #1;
    chk("t3_reload_ready", lnk.ready_o, 3'b001);
    nxt = src_flit[0];
    tick();
    chk("t3_next_flit", lnk.fdata_o, nxt);
    chk("t3_valid", lnk.valid_o, 1);

    // Same-cycle load and credit; then credit overflow
    do_reset();
    lnk.valid_i = 3'b001;
    lnk.ready_i = 1'b1;
    tick();
    lnk.credit_i = 3'b001;
    tick();
    tick();
    tick();
    chk("t4_pops", pops[0], 3);
    lnk.valid_i  = 3'b000;
    lnk.credit_i = 3'b100;
    tick();
    chk("t4_overflow_err", lnk.error_o, 1);
    lnk.valid_i = 3'b100;
    repeat (4) tick();
    chk("t4_vc2_pops", pops[2], 2);

    // Orphan body flit, then asynchronous reset mid-stream
    do_reset();
    set_flit(2, 34'h1_0000_0005);
    lnk.valid_i = 3'b100;
    lnk.ready_i = 1'b1;
    tick();
    chk("t5_vc", lnk.vc_id_o, 2);
    chk("t5_flit", lnk.fdata_o, 34'h1_0000_0005);
    chk("t5_err", lnk.error_o, 1);
    lnk.valid_i = 3'b111;
    repeat (2) tick();
    chk("t5_err_sticky", lnk.error_o, 1);
    #3;
    do_reset();
    lnk.valid_i = 3'b010;
    lnk.ready_i = 1'b1;
    repeat (4) tick();
    chk("t5_credit_reinit", pops[1], 2);

    // Wrap of the round-robin search
    do_reset();
    lnk.valid_i = 3'b011;
    lnk.ready_i = 1'b1;
    tick();
    tick();
    lnk.valid_i = 3'b001;
    #1;
    chk("t6_wrap", lnk.ready_o, 3'b001);
    tick();
    lnk.valid_i = 3'b011;
    #1;
    chk("t6_rr_next", lnk.ready_o, 3'b010);
    tick();

    // Randomized traffic with credits returned for accepted flits
    do_reset();
    for (int c = 0; c < 600; c++) begin
      lnk.ready_i = ($urandom_range(3) != 0);
      lnk.valid_i = N'($urandom);
      for (int v = 0; v < N; v++) begin
        if (pend[v] > 0 && $urandom_range(1) == 1) begin
          lnk.credit_i[v] = 1'b1;
          pend[v]--;
        end
      end
      tick();
    end
    total = pops[0] + pops[1] + pops[2];
    chk("rand_no_err", lnk.error_o, 0);
    chk("rand_traffic", (total > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_link_scheduler.md
Name: vc_link_scheduler

Overview:
- Output-side scheduler for one router output link, shared between N_VC virtual-channel buffers.
- Each cycle it selects one eligible VC by round-robin, loads that VC's flit into a single output pipeline register, and tags the flit with its VC id.
- An eligible VC has a flit pending and at least one downstream credit.
- Per-VC credit counters track free slots in the downstream vc_buffer instances.
- Per-VC packet-state flags detect wormhole framing errors.

Parameters:
N_VC, 3, number of virtual channels sharing the link (1..4; vc_id is 2 bits)
BUF_DEPTH, 2, flit slots per downstream VC buffer; initial and maximum credit count
FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous reset, active-low (arst=0 resets)
fdata_i  input  N_VC*FLIT_W  flattened VC head flits; VC v occupies [v*FLIT_W +: FLIT_W]
valid_i  input  N_VC  per-VC flit pending (the VC buffer's valid_o)
ready_o  output  N_VC  per-VC pop strobe (drives the VC buffer's ready_i)
fdata_o  output  FLIT_W  registered link flit
vc_id_o  output  2  VC id of fdata_o
valid_o  output  1  link flit valid
ready_i  input  1  link accepts the flit
credit_i  input  N_VC  one-cycle pulse per VC; downstream freed one slot
error_o  output  1  sticky protocol error

Behaviour:
- Reset (arst low, asynchronous): valid_o=0, fdata_o=0, vc_id_o=0, error_o=0, all credits=BUF_DEPTH, rr_ptr=0, all in_pkt=0. Reset mid-transfer drops the held flit; it is not replayed.
- Flit type encoding: 00 head, 01 body, 10 head+tail (single flit), 11 tail.
- eligible[v] = valid_i[v] & (credit[v] != 0).
- load = (!valid_o | ready_i) & |eligible.
- Grant: first eligible VC searching from rr_ptr upward, wrapping modulo N_VC. This is combinational, so ready_o is a pure function of state and inputs.
- ready_o[g] = load for the granted VC g. All other ready_o bits are 0. ready_o is never asserted for a VC with valid_i=0 or credit=0.
- On load (clock edge):
  - fdata_o <= fdata_i slice of g
  - vc_id_o <= g
  - valid_o <= 1
  - rr_ptr <= (g+1) mod N_VC
- If valid_o & ready_i & !load: valid_o <= 0; fdata_o and vc_id_o hold.
- Back-to-back: with ready_i held high and eligible VCs present, one flit per cycle. Latency from input pop to valid_o is 1 cycle.
- While valid_o=1 & ready_i=0: fdata_o, vc_id_o and valid_o are stable. No ready_o is asserted.
- Credit counters, width clog2(BUF_DEPTH+1):
  - decrement on load for g
  - increment on credit_i[v]
  - both in the same cycle for the same VC: no change
  - credit_i[v] when credit[v]==BUF_DEPTH (with no decrement): count stays at BUF_DEPTH, error_o <= 1
  - a counter never underflows, because of the eligibility rule
- Packet tracking (updated on load, per VC g):
  - head: in_pkt[g] <= 1; error if already 1
  - body: error if in_pkt[g]==0
  - tail: in_pkt[g] <= 0; error if in_pkt[g]==0
  - head+tail: error if in_pkt[g]==1; in_pkt[g] unchanged
- Flits of different VCs interleave freely at flit granularity; framing is checked per VC.
- error_o is sticky until arst. Errors do not block scheduling.
- No combinational path from ready_i to fdata_o or vc_id_o. ready_i reaches ready_o only through load.

Test Plan:
1. Reset, then valid_i=3'b111, all VCs stream head/body/tail, ready_i=1 -> vc_id_o sequence 0,1,2,0,1,2 starting 1 cycle after the first ready_o; one flit per cycle until credits run out.
2. Only VC1 valid, no credit_i, BUF_DEPTH=2 -> exactly 2 flits sent (ready_o[1] pulses twice), then ready_o[1]=0. Pulse credit_i[1] -> 1 more flit 1 cycle later.
3. valid_o=1 with ready_i=0 for 5 cycles -> fdata_o and vc_id_o unchanged, ready_o=0. Raise ready_i -> the next flit loads the same cycle, valid_o stays 1.
4. Same-cycle load on VC0 and credit_i[0] with credit[0]=1 -> credit[0] stays 1. Then credit_i[2] while credit[2]=2 -> credit[2] stays 2, error_o=1 on the next cycle.
5. VC2 sends body 34'h1_0000_0005 with in_pkt[2]=0 -> flit delivered with vc_id_o=2, error_o=1 and held. Then arst low mid-stream -> valid_o=0, error_o=0, credits=2, immediately and asynchronously.
6. Only VC0 valid with rr_ptr=2 -> grant VC0 (search wraps 2->0); rr_ptr becomes 1.
